muldiv_unit: RTL and testbench

- Iterative RV M-extension execute unit: MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU, plus RV64 word forms.
- Sits beside the integer ALU in the execute stage; pipeline stalls on in_ready/out_valid.
- Parametrised in XLEN. Radix-2, one bit per cycle, valid/ready handshakes on both sides, synchronous flush.

---
 rtl/muldiv_unit.sv | 152 +++++++++++++++
 tb/tb_muldiv_unit.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 RISC-V M-extension execute unit.
// Handles MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU and the RV64 W forms.
// Normal ops take one bit per cycle in CALC. Divide-by-zero and signed
// overflow bypass CALC and go straight to DONE.
// Ports:
//   clk, reset      rising-edge clock, async active-high reset
//   flush           synchronous kill of any in-flight or pending op
//   in_valid/ready  request handshake (op, is_word_op, a, b)
//   out_valid/ready result handshake; result is held while out_valid && !out_ready
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic            is_word_op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);
  localparam int CW = $clog2(XLEN + 1);
  localparam logic [1:0] IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2;
  localparam logic [XLEN-1:0] LO32 = XLEN'(64'hFFFF_FFFF);
  localparam logic [XLEN-1:0] MINV = {1'b1, {(XLEN-1){1'b0}}};

  function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] v);
    sext32 = (v & LO32) | (v[31] ? ~LO32 : '0);
  endfunction

  logic [1:0]      state;
  logic [CW-1:0]   cnt;
  logic [XLEN:0]   hi;      // multiply accumulator / division partial remainder
  logic [XLEN-1:0] lo;      // multiplier / dividend shifting into quotient
  logic [XLEN-1:0] d;       // multiplicand / divisor magnitude
  logic [2:0]      op_r;
  logic            word_r, neg_r;

  // ---- operand prep at accept ----
  logic            word, sgn_a, sgn_b, neg_a, neg_b, neg, div0, ovf, fast;
  logic [2:0]      eop;
  logic [XLEN-1:0] aw, bw, aabs, babs, fast_val, fast_res;

  assign word  = (XLEN == 64) && is_word_op;
  // W-form multiplies other than MULW do not exist; they collapse onto MULW.
  assign eop   = (word && !op[2]) ? 3'd0 : op;
  assign sgn_a = (eop == 3'd1) || (eop == 3'd2) || (eop == 3'd4) || (eop == 3'd6);
  assign sgn_b = (eop == 3'd1) || (eop == 3'd4) || (eop == 3'd6);
  assign aw    = word ? (sgn_a ? sext32(a) : (a & LO32)) : a;
  assign bw    = word ? (sgn_b ? sext32(b) : (b & LO32)) : b;
  assign neg_a = sgn_a && aw[XLEN-1];
  assign neg_b = sgn_b && bw[XLEN-1];
  assign aabs  = neg_a ? -aw : aw;
  assign babs  = neg_b ? -bw : bw;
  // Remainder follows the dividend; quotient and products follow sign(a)^sign(b).
  assign neg   = (eop[2] && eop[1]) ? neg_a : (neg_a ^ neg_b);

  assign div0  = eop[2] && (bw == '0);
  assign ovf   = (eop == 3'd4 || eop == 3'd6) &&
                 (word ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                       : (a == MINV && (&b)));
  assign fast  = div0 || ovf;
  assign fast_val = div0 ? (eop[1] ? aw : '1) : (eop[1] ? '0 : aw);
  assign fast_res = word ? sext32(fast_val) : fast_val;

  // ---- one iteration ----
  logic [XLEN:0]   msum, dsh, nhi;
  logic [XLEN-1:0] nlo;
  logic            dge;

  always_comb begin
    msum = hi + {1'b0, (lo[0] ? d : '0)};
    dsh  = {hi[XLEN-1:0], lo[XLEN-1]};
    dge  = dsh >= {1'b0, d};
    if (op_r[2]) begin
      nhi = dge ? (dsh - {1'b0, d}) : dsh;
      nlo = {lo[XLEN-2:0], dge};
    end else begin
      nhi = {1'b0, msum[XLEN:1]};
      nlo = {msum[0], lo[XLEN-1:1]};
    end
  end

  // ---- final result from the last iteration's values ----
  logic [XLEN-1:0] mh, mhi, mlo, dv, dn, fin;

  always_comb begin
    mh  = nhi[XLEN-1:0];
    // High half of -{mh,nlo}: carry into the high half only when the low half is zero.
    mhi = neg_r ? (~mh + {{(XLEN-1){1'b0}}, (nlo == '0)}) : mh;
    // A 32-iteration multiply in an XLEN-wide register leaves the low product
    // word at the top of lo.
    mlo = word_r ? sext32(nlo >> (XLEN - 32)) : nlo;
    dv  = op_r[1] ? nhi[XLEN-1:0] : nlo;
    dn  = neg_r ? -dv : dv;
    if (op_r[2]) fin = word_r ? sext32(dn) : dn;
    else         fin = (op_r[1:0] == 2'd0) ? mlo : mhi;
  end

  assign in_ready  = (state == IDLE) && !flush;
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
      d      <= '0;
      op_r   <= '0;
      word_r <= 1'b0;
      neg_r  <= 1'b0;
      result <= '0;
    end else if (flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          op_r   <= eop;
          word_r <= word;
          neg_r  <= neg;
          hi     <= '0;
          // Word divides pre-shift the dividend so its MSB is consumed first.
          lo     <= eop[2] ? (word ? (aabs << (XLEN - 32)) : aabs) : babs;
          d      <= eop[2] ? babs : aabs;
          cnt    <= word ? CW'(32) : CW'(XLEN);
          if (fast) begin
            state  <= DONE;
            result <= fast_res;
          end else begin
            state  <= CALC;
          end
        end
        CALC: begin
          hi  <= nhi;
          lo  <= nlo;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state  <= DONE;
            result <= fin;
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        flush32, iv32, ir32, wo32, ov32, or32;
  logic [2:0]  op32;
  logic [31:0] a32, b32, r32;
  logic        flush64, iv64, ir64, wo64, ov64, or64;
  logic [2:0]  op64;
  logic [63:0] a64, b64, r64;

  muldiv_unit #(.XLEN(32)) u32 (
    .clk(clk), .reset(reset), .flush(flush32), .in_valid(iv32), .in_ready(ir32),
    .op(op32), .is_word_op(wo32), .a(a32), .b(b32),
    .out_valid(ov32), .out_ready(or32), .result(r32));

  muldiv_unit #(.XLEN(64)) u64 (
    .clk(clk), .reset(reset), .flush(flush64), .in_valid(iv64), .in_ready(ir64),
    .op(op64), .is_word_op(wo64), .a(a64), .b(b64),
    .out_valid(ov64), .out_ready(or64), .result(r64));

  typedef struct {
    logic [63:0] res;
    int          lat;
    longint      acc;
  } exp_t;

  exp_t   q32[$], q64[$];
  int     n_cmp = 0, n_err = 0;
  longint cyc = 0;
  bit     rnd_rdy = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail(input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  // Reference model: plain arithmetic on the operand values.
  function automatic void model(input int xlen, input logic [2:0] op_i, input logic word_i,
                                input logic [63:0] a, input logic [63:0] b,
                                output logic [63:0] res, output int lat);
    int w;
    logic [2:0] o;
    longint sa, sb, mn;
    logic [63:0] ua, ub, v;
    logic signed [127:0] pa, pb, p;
    w  = (xlen == 64 && word_i) ? 32 : xlen;
    o  = (xlen == 64 && word_i && !op_i[2]) ? 3'd0 : op_i;
    ua = (w == 32) ? {32'b0, a[31:0]} : a;
    ub = (w == 32) ? {32'b0, b[31:0]} : b;
    sa = (w == 32) ? longint'(signed'(a[31:0])) : longint'(a);
    sb = (w == 32) ? longint'(signed'(b[31:0])) : longint'(b);
    mn = (w == 32) ? longint'(64'hFFFF_FFFF_8000_0000) : longint'(64'h8000_0000_0000_0000);
    lat = w + 1;
    if (!o[2]) begin
      pa = (o == 3'd1 || o == 3'd2) ? {{64{sa[63]}}, sa} : {64'b0, ua};
      pb = (o == 3'd1) ? {{64{sb[63]}}, sb} : {64'b0, ub};
      p  = pa * pb;
      if (o == 3'd0)    v = p[63:0];
      else if (w == 32) v = {32'b0, p[63:32]};
      else              v = p[127:64];
    end else if (ub == 64'd0) begin
      lat = 1;
      v = o[1] ? ua : '1;
    end else if (!o[0] && sa == mn && sb == -1) begin
      lat = 1;
      v = o[1] ? 64'd0 : ua;
    end else if (!o[0]) begin
      v = o[1] ? (sa % sb) : (sa / sb);
    end else begin
      v = o[1] ? (ua % ub) : (ua / ub);
    end
    res = (w == 32) ? {{32{v[31]}}, v[31:0]} : v;
  endfunction

  task automatic issue(input bit is64, input logic [2:0] o, input logic w,
                       input logic [63:0] av, input logic [63:0] bv,
                       input logic [63:0] er, input int el, input bit push);
    exp_t e;
    int t;
    @(negedge clk);
    if (is64) begin iv64 = 1; op64 = o; wo64 = w; a64 = av; b64 = bv; end
    else      begin iv32 = 1; op32 = o; wo32 = w; a32 = av[31:0]; b32 = bv[31:0]; end
    #1;
    t = 0;
    while (!(is64 ? ir64 : ir32) && t < 500) begin @(negedge clk); #1; t++; end
    if (t >= 500) fail("accept_timeout");
    e.res = er; e.lat = el; e.acc = cyc;
    if (push) begin
      if (is64) q64.push_back(e); else q32.push_back(e);
    end
    @(posedge clk); #1;
    if (is64) begin iv64 = 0; a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom}; end
    else      begin iv32 = 0; a32 = $urandom; b32 = $urandom; end
  endtask

  task automatic drain();
    int t = 0;
    while ((q32.size() != 0 || q64.size() != 0 || !ir32 || !ir64) && t < 3000) begin
      @(negedge clk); #1; t++;
    end
    if (t >= 3000) fail("drain_timeout");
  endtask

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 5))
      0: pick = 64'd0;
      1: pick = 64'd1;
      2: pick = '1;
      3: pick = {$urandom, 32'h8000_0000};
      4: pick = 64'h8000_0000_0000_0000;
      default: pick = {$urandom, $urandom};
    endcase
  endfunction

  task automatic rand_ops(input bit is64, input int n);
    for (int i = 0; i < n; i++) begin
      logic [2:0] o;
      logic w;
      logic [63:0] av, bv, er;
      int el;
      o = 3'($urandom_range(0, 7));
      w = 1'($urandom_range(0, 1));
      av = pick();
      bv = pick();
      if (!is64) begin av[63:32] = '0; bv[63:32] = '0; end
      model(is64 ? 64 : 32, o, w, av, bv, er, el);
      issue(is64, o, w, av, bv, er, el, 1);
    end
  endtask

  initial forever begin
    @(posedge clk); #2;
    if (rnd_rdy) begin
      or32 = ($urandom_range(0, 3) != 0);
      or64 = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitors: latency on the rising edge of out_valid, hold stability while
  // stalled, and result compare on the handshake.
  logic        pv32 = 0, pv64 = 0;
  logic [63:0] held32, held64;

  always @(negedge clk) begin
    if (reset) pv32 = 0;
    else begin
      if (ov32 && !pv32) begin
        if (q32.size() == 0) fail("unexpected_out32");
        else begin
          chk("lat32", 64'(cyc - q32[0].acc), 64'(q32[0].lat));
          held32 = {32'b0, r32};
        end
      end else if (ov32) chk("hold32", {32'b0, r32}, held32);
      if (ov32 && or32 && q32.size() != 0) begin
        exp_t e;
        e = q32.pop_front();
        chk("res32", {32'b0, r32}, {32'b0, e.res[31:0]});
      end
      pv32 = ov32 && !or32;
    end
  end

  always @(negedge clk) begin
    if (reset) pv64 = 0;
    else begin
      if (ov64 && !pv64) begin
        if (q64.size() == 0) fail("unexpected_out64");
        else begin
          chk("lat64", 64'(cyc - q64[0].acc), 64'(q64[0].lat));
          held64 = r64;
        end
      end else if (ov64) chk("hold64", r64, held64);
      if (ov64 && or64 && q64.size() != 0) begin
        exp_t e;
        e = q64.pop_front();
        chk("res64", r64, e.res);
      end
      pv64 = ov64 && !or64;
    end
  end

  logic [2:0]  d_op [9] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd7, 3'd4, 3'd6, 3'd6};
  logic [31:0] d_a  [9] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5, 32'd5,
                            32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFF9};
  logic [31:0] d_b  [9] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0,
                            32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2};
  logic [31:0] d_e  [9] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF,
                            32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF};
  int          d_l  [9] = '{33, 33, 33, 33, 1, 1, 1, 1, 33};

  initial begin
    int t;
    reset = 1;
    flush32 = 0; iv32 = 0; wo32 = 0; op32 = 0; a32 = 0; b32 = 0; or32 = 1;
    flush64 = 0; iv64 = 0; wo64 = 0; op64 = 0; a64 = 0; b64 = 0; or64 = 1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ir32", {63'b0, ir32}, 64'd1);
    chk("rst_ov32", {63'b0, ov32}, 64'd0);
    chk("rst_res32", {32'b0, r32}, 64'd0);
    chk("rst_ir64", {63'b0, ir64}, 64'd1);
    chk("rst_ov64", {63'b0, ov64}, 64'd0);
    chk("rst_res64", r64, 64'd0);
    @(negedge clk);
    reset = 0;

    // XLEN=32 directed cases
    for (int i = 0; i < 9; i++)
      issue(0, d_op[i], 1'b0, {32'b0, d_a[i]}, {32'b0, d_b[i]}, {32'b0, d_e[i]}, d_l[i], 1);
    drain();

    // Stall on the output side: result held, no new accept
    @(posedge clk); #2; or32 = 0;
    issue(0, 3'd4, 1'b0, 64'hFFFF_FFF9, 64'd2, 64'hFFFF_FFFD, 33, 1);
    t = 0;
    while (!ov32 && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) fail("hold_wait_timeout");
    repeat (5) begin
      @(negedge clk); #1;
      chk("hold_ir32", {63'b0, ir32}, 64'd0);
      chk("hold_ov32", {63'b0, ov32}, 64'd1);
    end
    @(posedge clk); #2; or32 = 1;
    @(negedge clk); @(negedge clk); #1;
    chk("idle_after_rdy_ir32", {63'b0, ir32}, 64'd1);
    chk("idle_after_rdy_ov32", {63'b0, ov32}, 64'd0);

    // Flush in the middle of CALC: the op vanishes
    issue(0, 3'd0, 1'b0, 64'd12345, 64'd678, 64'd0, 0, 0);
    repeat (9) @(negedge clk);
    flush32 = 1;
    @(negedge clk);
    flush32 = 0;
    #1;
    chk("flush_ov32", {63'b0, ov32}, 64'd0);
    chk("flush_ir32", {63'b0, ir32}, 64'd1);
    repeat (40) @(negedge clk);
    #1;
    chk("flush_quiet_ov32", {63'b0, ov32}, 64'd0);

    // XLEN=64 word forms
    issue(1, 3'd4, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33, 1);
    issue(1, 3'd5, 1'b1, 64'h0000_0000_8000_0000, 64'd1, 64'hFFFF_FFFF_8000_0000, 33, 1);
    drain();

    // Reset in the middle of CALC, then a fresh 64-bit MUL
    issue(1, 3'd0, 1'b0, 64'hDEAD_BEEF_0123_4567, 64'd99, 64'd0, 0, 0);
    repeat (10) @(negedge clk);
    #1 reset = 1;
    #1;
    chk("midrst_ov64", {63'b0, ov64}, 64'd0);
    chk("midrst_ir64", {63'b0, ir64}, 64'd1);
    chk("midrst_res64", r64, 64'd0);
    @(negedge clk);
    reset = 0;
    issue(1, 3'd0, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'd3, 64'h369D_0369_D036_9CD0, 65, 1);
    drain();

    // Randomized traffic with random back-pressure
    rnd_rdy = 1;
    rand_ops(0, 40);
    rand_ops(1, 40);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
